// File: rtl/aes_pkg.sv
// Shared AES decrypt constants and byte/state helpers:
// DATA_W/BYTE_W, inv_sbox ROM, xtime, inv_shift_rows.
package aes_pkg;

  localparam int DATA_W = 128;
  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] inv_sbox(
    input logic [BYTE_W-1:0] b
  );
    logic [BYTE_W-1:0] r;
    r = '0;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5;
      8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e;
      8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82;
      8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44;
      8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32;
      8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b;
      8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66;
      8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49;
      8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64;
      8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc;
      8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50;
      8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57;
      8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00;
      8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05;
      8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f;
      8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03;
      8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41;
      8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce;
      8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22;
      8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8;
      8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71;
      8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e;
      8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b;
      8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe;
      8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33;
      8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59;
      8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9;
      8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f;
      8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d;
      8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c;
      8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e;
      8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63;
      8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(
    input logic [BYTE_W-1:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the state sits at [127-8n -: 8], n = row + 4*col.
  // Row r moves right by r: out[r][c] = in[r][(c-r) mod 4].
  function automatic logic [DATA_W-1:0] inv_shift_rows(
    input logic [DATA_W-1:0] s
  );
    logic [DATA_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[DATA_W-1-8*(4*c+r) -: 8] =
          s[DATA_W-1-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column.
// Ports: col (row0 in [31:24]) -> mixed.
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [BYTE_W-1:0] a  [4];
  logic [BYTE_W-1:0] x2 [4];
  logic [BYTE_W-1:0] x4 [4];
  logic [BYTE_W-1:0] x8 [4];
  logic [BYTE_W-1:0] m9 [4];
  logic [BYTE_W-1:0] mb [4];
  logic [BYTE_W-1:0] md [4];
  logic [BYTE_W-1:0] me [4];

  // 09/0b/0d/0e built from the x2/x4/x8 xtime chain.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign mixed = {
    me[0] ^ mb[1] ^ md[2] ^ m9[3],
    m9[0] ^ me[1] ^ mb[2] ^ md[3],
    md[0] ^ m9[1] ^ me[2] ^ mb[3],
    mb[0] ^ md[1] ^ m9[2] ^ me[3]
  };

endmodule

// File: rtl/aes_inv_round.sv
// Two-stage AES inverse round: InvShiftRows+InvSubBytes, then
// AddRoundKey and optional InvMixColumns. Ports: clk, reset (sync,
// active-low), data/key valids, last_round, data_in, round_key,
// valid_out, data_out.
module aes_inv_round #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid_in,
  input  logic              key_valid_in,
  input  logic              last_round,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] round_key,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);
  import aes_pkg::*;

  logic              accept;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] subbed;
  logic              s1_valid;
  logic              s1_last;
  logic [DATA_W-1:0] s1_state;
  logic [DATA_W-1:0] s1_key;
  logic [DATA_W-1:0] t;
  logic [DATA_W-1:0] mixed;

  // Data and key must arrive together; a lone valid is a bubble.
  assign accept  = data_valid_in && key_valid_in;
  assign shifted = inv_shift_rows(data_in);

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[DATA_W-1-8*i -: 8] = inv_sbox(shifted[DATA_W-1-8*i -: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_state <= '0;
      s1_key   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_state <= subbed;
        s1_key   <= round_key;
        s1_last  <= last_round;
      end
    end
  end

  assign t = s1_state ^ s1_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mix_column u_mix (
      .col   (t[DATA_W-1-32*c -: 32]),
      .mixed (mixed[DATA_W-1-32*c -: 32])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        data_out <= s1_last ? t : mixed;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round using FIPS-197
// inverse-cipher vectors and directed corner cases.
module tb_aes_inv_round;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in;
  logic         key_valid_in;
  logic         last_round;
  logic [127:0] data_in;
  logic [127:0] round_key;
  logic         valid_out;
  logic [127:0] data_out;

  logic [127:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  localparam logic [127:0] V1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] K1 = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] E1 = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] V2 = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E0 = {16{8'h52}};

  always #5 clk = ~clk;

  aes_inv_round dut (
    .clk           (clk),
    .reset         (reset),
    .data_valid_in (data_valid_in),
    .key_valid_in  (key_valid_in),
    .last_round    (last_round),
    .data_in       (data_in),
    .round_key     (round_key),
    .valid_out     (valid_out),
    .data_out      (data_out)
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data_out=%h want no output",
                 data_out);
      end else begin
        check("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k,
                      input logic l, input logic [127:0] e,
                      input bit push);
    @(negedge clk);
    data_valid_in = 1'b1;
    key_valid_in  = 1'b1;
    last_round    = l;
    data_in       = d;
    round_key     = k;
    if (push) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid_in = 1'b0;
      key_valid_in  = 1'b0;
    end
  endtask

  initial begin
    reset         = 1'b0;
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    last_round    = 1'b0;
    data_in       = '0;
    round_key     = '0;
    idle(3);
    check("reset_valid", {127'd0, valid_out}, 128'd0);
    check("reset_data", data_out, 128'd0);
    reset = 1'b1;
    idle(2);

    send(V1, K1, 1'b0, E1, 1'b1);
    idle(4);
    send(V2, K2, 1'b1, E2, 1'b1);
    idle(4);

    send('0, '0, 1'b0, E0, 1'b1);
    send('0, '0, 1'b1, E0, 1'b1);
    idle(4);

    // Lone valids are bubbles; data_out must hold.
    @(negedge clk);
    data_valid_in = 1'b1;
    key_valid_in  = 1'b0;
    data_in       = V1;
    round_key     = K1;
    @(negedge clk);
    data_valid_in = 1'b0;
    key_valid_in  = 1'b1;
    data_in       = V2;
    idle(1);
    data_in = 'x;
    idle(3);
    check("bubble_valid", {127'd0, valid_out}, 128'd0);
    check("bubble_hold", data_out, E0);
    data_in = '0;

    // Reset one cycle after the second accept drops V2.
    send(V1, K1, 1'b0, E1, 1'b1);
    send(V2, K2, 1'b1, E2, 1'b0);
    @(negedge clk);
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    reset         = 1'b0;
    @(negedge clk);
    check("midflight_valid", {127'd0, valid_out}, 128'd0);
    check("midflight_data", data_out, 128'd0);
    reset = 1'b1;
    idle(4);

    // Reset coincident with an accept: reset wins.
    send(V1, K1, 1'b0, E1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset         = 1'b1;
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    idle(4);
    check("reset_wins_data", data_out, 128'd0);

    send(V1, K1, 1'b0, E1, 1'b1);
    send(V2, K2, 1'b1, E2, 1'b1);
    send('0, '0, 1'b0, E0, 1'b1);
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
